// File: rtl/tiro_uc.sv
// Shot-store control unit: clears the 16 slots, allocates a slot on fire and
// walks every slot on each game tick to move, retire or report hits.
module tiro_uc (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       atirar,
    input  logic       tick,
    input  logic       loaded,
    input  logic       colisao,
    input  logic       rco_contador,
    input  logic [1:0] opcode,
    input  logic       x_borda_min,
    input  logic       x_borda_max,
    input  logic       y_borda_min,
    input  logic       y_borda_max,
    output logic       conta_contador,
    output logic       reset_cont,
    output logic [1:0] select_mux_pos,
    output logic       select_mux_coor,
    output logic       select_soma_sub,
    output logic       enable_reg_nave,
    output logic       reset_reg_nave,
    output logic       enable_mem_aste,
    output logic       enable_mem_load,
    output logic       new_load,
    output logic       new_destruido,
    output logic       tiro_perdido,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        StInicial  = 4'd0,
        StLimpa    = 4'd1,
        StEspera   = 4'd2,
        StNovoTiro = 4'd3,
        StBusca    = 4'd4,
        StGrava    = 4'd5,
        StPerdido  = 4'd6,
        StVarre    = 4'd7,
        StLeSlot   = 4'd8,
        StMove     = 4'd9,
        StColide   = 4'd10,
        StAcerto   = 4'd11,
        StDescarte = 4'd12,
        StProximo  = 4'd13
    } state_e;

    state_e r_state;
    state_e w_next;
    logic   r_tiro_pend;
    logic   r_tick_pend;
    logic   w_borda;

    // A new request in the same cycle as the service entry keeps the flag set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StInicial;
            r_tiro_pend <= 1'b0;
            r_tick_pend <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_tiro_pend <= atirar | (r_tiro_pend & (w_next != StNovoTiro));
            r_tick_pend <= tick | (r_tick_pend & (w_next != StVarre));
        end
    end

    // Edge that stops a shot travelling in the addressed slot's direction.
    always_comb begin
        w_borda = x_borda_max;
        case (opcode)
            2'b00:   w_borda = y_borda_min;
            2'b01:   w_borda = y_borda_max;
            2'b10:   w_borda = x_borda_min;
            default: w_borda = x_borda_max;
        endcase
    end

    always_comb begin
        w_next          = r_state;
        conta_contador  = 1'b0;
        reset_cont      = 1'b0;
        select_mux_pos  = 2'b00;
        select_mux_coor = 1'b0;
        select_soma_sub = 1'b0;
        enable_reg_nave = 1'b0;
        reset_reg_nave  = 1'b0;
        enable_mem_aste = 1'b0;
        enable_mem_load = 1'b0;
        new_load        = 1'b0;
        new_destruido   = 1'b0;
        tiro_perdido    = 1'b0;
        ocupado         = (r_state != StEspera);
        db_estado       = r_state;
        case (r_state)
            StInicial: begin
                reset_cont     = 1'b1;
                reset_reg_nave = 1'b1;
                w_next         = StLimpa;
            end
            StLimpa: begin
                enable_mem_load = 1'b1;
                conta_contador  = 1'b1;
                if (rco_contador) w_next = StEspera;
            end
            StEspera: begin
                if (r_tiro_pend)      w_next = StNovoTiro;
                else if (r_tick_pend) w_next = StVarre;
            end
            StNovoTiro: begin
                reset_cont      = 1'b1;
                enable_reg_nave = 1'b1;
                w_next          = StBusca;
            end
            StBusca: begin
                if (!loaded)           w_next = StGrava;
                else if (rco_contador) w_next = StPerdido;
                else                   conta_contador = 1'b1;
            end
            StGrava: begin
                enable_mem_aste = 1'b1;
                enable_mem_load = 1'b1;
                new_load        = 1'b1;
                w_next          = StEspera;
            end
            StPerdido: begin
                tiro_perdido = 1'b1;
                w_next       = StEspera;
            end
            StVarre: begin
                reset_cont = 1'b1;
                w_next     = StLeSlot;
            end
            StLeSlot: begin
                select_mux_pos = 2'b10;
                if (!loaded)      w_next = StProximo;
                else if (w_borda) w_next = StDescarte;
                else              w_next = StMove;
            end
            StMove: begin
                // opcode[1] picks X; even opcodes (up/left) step by -1.
                select_mux_pos  = 2'b01;
                select_mux_coor = opcode[1];
                select_soma_sub = ~opcode[0];
                enable_mem_aste = 1'b1;
                w_next          = StColide;
            end
            StColide: begin
                select_mux_pos = 2'b10;
                w_next         = colisao ? StAcerto : StProximo;
            end
            StAcerto: begin
                new_destruido   = 1'b1;
                enable_mem_load = 1'b1;
                w_next          = StProximo;
            end
            StDescarte: begin
                enable_mem_load = 1'b1;
                w_next          = StProximo;
            end
            StProximo: begin
                if (rco_contador) begin
                    w_next = StEspera;
                end else begin
                    conta_contador = 1'b1;
                    w_next         = StLeSlot;
                end
            end
            default: w_next = StInicial;
        endcase
    end

endmodule
